// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I decode stage for the multi-cycle core.
// Holds the fetched instruction (IR) and its PC (PCR), decodes control
// signals and the immediate from IR, and owns the architectural register
// file. The write-back stage writes results through this block, targeting
// the rd field of the instruction currently held in IR.
module id_decode_stage #(
  parameter int          NREGS       = 32,
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_en_ID,
  input  logic        i_en_WB,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_funct3,
  output logic        o_funct7b5,
  output logic        o_RegWrite,
  output logic        o_ALUSrc,
  output logic        o_ALUSrcA_pc,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_MemtoReg,
  output logic        o_Branch,
  output logic        o_Jump,
  output logic        o_JumpReg,
  output logic [1:0]  o_ALUOp,
  output logic        o_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  logic [31:0] ir_q, ir_d;
  logic [31:0] pcr_q, pcr_d;
  logic [31:0] rf_q [NREGS];

  logic [6:0]  opcode;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        is_lui;
  logic        wr_en;
  imm_fmt_e    imm_fmt;

  assign opcode     = ir_q[6:0];
  assign rs1_addr   = ir_q[19:15];
  assign rs2_addr   = ir_q[24:20];
  assign o_rd       = ir_q[11:7];
  assign o_funct3   = ir_q[14:12];
  assign o_funct7b5 = ir_q[30];
  assign o_pc       = pcr_q;
  assign is_lui     = (opcode == OP_LUI);

  // A write-back only lands when the held instruction writes a real register.
  assign wr_en = i_en_WB && o_RegWrite && (o_rd != 5'd0) && (int'(o_rd) < NREGS);

  // Next-state for IR/PCR: load on the capture strobe, otherwise hold.
  always_comb begin
    ir_d  = ir_q;
    pcr_d = pcr_q;
    if (i_en_ID) begin
      ir_d  = i_instr;
      pcr_d = i_pc;
    end
  end

  // IR/PCR registers and register file; reset overrides capture and write-back.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ir_q  <= RESET_INSTR;
      pcr_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      ir_q  <= ir_d;
      pcr_q <= pcr_d;
      // rd comes from the IR value before this edge's capture.
      if (wr_en) begin
        rf_q[o_rd] <= i_wb_data;
      end
    end
  end

  // Opcode decode: control signals and immediate format; unknown opcodes flag illegal.
  always_comb begin
    o_RegWrite   = 1'b0;
    o_ALUSrc     = 1'b0;
    o_ALUSrcA_pc = 1'b0;
    o_MemRead    = 1'b0;
    o_MemWrite   = 1'b0;
    o_MemtoReg   = 1'b0;
    o_Branch     = 1'b0;
    o_Jump       = 1'b0;
    o_JumpReg    = 1'b0;
    o_ALUOp      = 2'b00;
    o_illegal    = 1'b0;
    imm_fmt      = IMM_NONE;
    unique case (opcode)
      OP_R: begin
        o_RegWrite = 1'b1;
        o_ALUOp    = 2'b10;
      end
      OP_IALU: begin
        o_RegWrite = 1'b1;
        o_ALUSrc   = 1'b1;
        o_ALUOp    = 2'b11;
        imm_fmt    = IMM_I;
      end
      OP_LOAD: begin
        o_RegWrite = 1'b1;
        o_ALUSrc   = 1'b1;
        o_MemRead  = 1'b1;
        o_MemtoReg = 1'b1;
        imm_fmt    = IMM_I;
      end
      OP_STORE: begin
        o_ALUSrc   = 1'b1;
        o_MemWrite = 1'b1;
        imm_fmt    = IMM_S;
      end
      OP_BRANCH: begin
        o_Branch = 1'b1;
        o_ALUOp  = 2'b01;
        imm_fmt  = IMM_B;
      end
      OP_JAL: begin
        o_RegWrite   = 1'b1;
        o_Jump       = 1'b1;
        o_ALUSrcA_pc = 1'b1;
        o_ALUSrc     = 1'b1;
        imm_fmt      = IMM_J;
      end
      OP_JALR: begin
        o_RegWrite = 1'b1;
        o_Jump     = 1'b1;
        o_JumpReg  = 1'b1;
        o_ALUSrc   = 1'b1;
        imm_fmt    = IMM_I;
      end
      OP_LUI: begin
        o_RegWrite = 1'b1;
        o_ALUSrc   = 1'b1;
        imm_fmt    = IMM_U;
      end
      OP_AUIPC: begin
        o_RegWrite   = 1'b1;
        o_ALUSrc     = 1'b1;
        o_ALUSrcA_pc = 1'b1;
        imm_fmt      = IMM_U;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  // Immediate assembly, sign-extended from instr[31].
  always_comb begin
    o_imm = '0;
    unique case (imm_fmt)
      IMM_I:   o_imm = {{20{ir_q[31]}}, ir_q[31:20]};
      IMM_S:   o_imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      IMM_B:   o_imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      IMM_U:   o_imm = {ir_q[31:12], 12'b0};
      IMM_J:   o_imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

  // Operand reads: x0 reads zero, same-cycle write-back bypasses the array, LUI zeroes rs1.
  always_comb begin
    o_rs1_data = '0;
    o_rs2_data = '0;
    if ((rs1_addr != 5'd0) && (int'(rs1_addr) < NREGS)) begin
      if (wr_en && (o_rd == rs1_addr)) begin
        o_rs1_data = i_wb_data;
      end else begin
        o_rs1_data = rf_q[rs1_addr];
      end
    end
    if ((rs2_addr != 5'd0) && (int'(rs2_addr) < NREGS)) begin
      if (wr_en && (o_rd == rs2_addr)) begin
        o_rs2_data = i_wb_data;
      end else begin
        o_rs2_data = rf_q[rs2_addr];
      end
    end
    if (is_lui) begin
      o_rs1_data = '0;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage with an expected-value scoreboard.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc, wb_data;
  logic        en_id, en_wb;
  logic [31:0] o_pc, rs1_d, rs2_d, imm;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        f7b5;
  logic        RegWrite, ALUSrc, ALUSrcA_pc, MemRead, MemWrite, MemtoReg;
  logic        Branch, Jump, JumpReg, illegal;
  logic [1:0]  ALUOp;
  logic [11:0] ctrl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  // Control bundle: RegWrite ALUSrc ALUSrcA_pc MemRead MemWrite MemtoReg Branch Jump JumpReg ALUOp illegal
  localparam logic [11:0] C_IALU   = 12'b110000000110;
  localparam logic [11:0] C_R      = 12'b100000000100;
  localparam logic [11:0] C_LOAD   = 12'b110101000000;
  localparam logic [11:0] C_STORE  = 12'b010010000000;
  localparam logic [11:0] C_BRANCH = 12'b000000100010;
  localparam logic [11:0] C_JAL    = 12'b111000010000;
  localparam logic [11:0] C_JALR   = 12'b110000011000;
  localparam logic [11:0] C_LUI    = 12'b110000000000;
  localparam logic [11:0] C_AUIPC  = 12'b111000000000;
  localparam logic [11:0] C_ILL    = 12'b000000000001;

  assign ctrl = {RegWrite, ALUSrc, ALUSrcA_pc, MemRead, MemWrite, MemtoReg,
                 Branch, Jump, JumpReg, ALUOp, illegal};

  id_decode_stage dut (
    .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_pc(pc),
    .i_en_ID(en_id), .i_en_WB(en_wb), .i_wb_data(wb_data),
    .o_pc(o_pc), .o_rs1_data(rs1_d), .o_rs2_data(rs2_d), .o_imm(imm),
    .o_rd(rd), .o_funct3(funct3), .o_funct7b5(f7b5),
    .o_RegWrite(RegWrite), .o_ALUSrc(ALUSrc), .o_ALUSrcA_pc(ALUSrcA_pc),
    .o_MemRead(MemRead), .o_MemWrite(MemWrite), .o_MemtoReg(MemtoReg),
    .o_Branch(Branch), .o_Jump(Jump), .o_JumpReg(JumpReg),
    .o_ALUOp(ALUOp), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rdx, input logic [4:0] r1, input logic [4:0] r2);
    return {7'b0, r2, r1, 3'b000, rdx, 7'b0110011};
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic capture(input logic [31:0] ins, input logic [31:0] pcv);
    instr = ins;
    pc    = pcv;
    en_id = 1'b1;
    @(posedge clk);
    #1;
    en_id = 1'b0;
    #1;
  endtask

  task automatic writeback(input logic [31:0] d);
    wb_data = d;
    en_wb   = 1'b1;
    @(posedge clk);
    #1;
    en_wb = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = '0; pc = '0; wb_data = '0; en_id = 1'b0; en_wb = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state: IR=NOP decodes as addi x0
    push("rst_pc", 32'h0);      chk(o_pc);
    push("rst_rd", 32'h0);      chk(32'(rd));
    push("rst_imm", 32'h0);     chk(imm);
    push("rst_ctrl", 32'(C_IALU)); chk(32'(ctrl));
    push("rst_rs1", 32'h0);     chk(rs1_d);

    // Every register reads 0 after reset
    for (int i = 0; i < 32; i++) begin
      push("rst_rf_rs1", 32'h0);
      push("rst_rf_rs2", 32'h0);
      capture(rtype(5'd0, 5'(i), 5'(31 - i)), 32'h100);
      chk(rs1_d);
      chk(rs2_d);
    end

    // addi x1,x0,5 then write back 5
    push("addi_imm", 32'd5); push("addi_rd", 32'd1);
    push("addi_ctrl", 32'(C_IALU)); push("addi_pc", 32'h10);
    capture(32'h00500093, 32'h10);
    chk(imm); chk(32'(rd)); chk(32'(ctrl)); chk(o_pc);
    writeback(32'd5);

    // sw x2,8(x1): reads x1=5; write-back ignored since store has no RegWrite
    push("sw_ctrl", 32'(C_STORE)); push("sw_imm", 32'd8);
    push("sw_rs1", 32'd5); push("sw_rs2", 32'd0); push("sw_pc", 32'h14);
    capture(32'h0020A423, 32'h14);
    chk(32'(ctrl)); chk(imm); chk(rs1_d); chk(rs2_d); chk(o_pc);
    writeback(32'h99);
    push("store_nowrite_x8", 32'h0);
    capture(rtype(5'd0, 5'd8, 5'd0), 32'h18);
    chk(rs1_d);

    // lui x2,0x200 (rs2 field = 2): bypass in the write cycle
    push("lui2_imm", 32'h00200000); push("lui2_ctrl", 32'(C_LUI));
    capture(32'h00200137, 32'h1C);
    chk(imm); chk(32'(ctrl));
    wb_data = 32'h0000DEAD;
    en_wb   = 1'b1;
    #2;
    push("bypass_rs2", 32'h0000DEAD); chk(rs2_d);
    push("bypass_lui_rs1", 32'h0);    chk(rs1_d);
    @(posedge clk);
    #1;
    en_wb = 1'b0;
    #1;
    push("x2_stored", 32'h0000DEAD); chk(rs2_d);

    // addi x3,x3,1: rs1 bypass
    capture(32'h00118193, 32'h20);
    wb_data = 32'h00001234;
    en_wb   = 1'b1;
    #2;
    push("bypass_rs1", 32'h00001234); chk(rs1_d);

    // Simultaneous capture and write-back: write lands in old rd (x3)
    wb_data = 32'h55;
    push("simul_rs1_x3", 32'h55); push("simul_rs2_x6", 32'h0); push("simul_ctrl", 32'(C_R));
    capture(32'h00618333, 32'h24);
    en_wb = 1'b0;
    #1;
    chk(rs1_d); chk(rs2_d); chk(32'(ctrl));

    // beq x0,x0,-4
    push("beq_imm", 32'hFFFFFFFC); push("beq_ctrl", 32'(C_BRANCH));
    capture(32'hFE000EE3, 32'h28);
    chk(imm); chk(32'(ctrl));

    // addi x8,x0,0x77 so the lui rs1 field (x8) holds a nonzero value
    capture(32'h07700413, 32'h2C);
    writeback(32'h77);
    push("lui5_imm", 32'h12345000); push("lui5_rs1", 32'h0);
    push("lui5_rd", 32'd5); push("lui5_ctrl", 32'(C_LUI));
    capture(32'h123452B7, 32'h30);
    chk(imm); chk(rs1_d); chk(32'(rd)); chk(32'(ctrl));
    push("x8_read", 32'h77);
    capture(rtype(5'd0, 5'd8, 5'd0), 32'h34);
    chk(rs1_d);

    // Other formats: jal, jalr, load, auipc
    push("jal_imm", 32'd8); push("jal_ctrl", 32'(C_JAL));
    capture(32'h008000EF, 32'h38);
    chk(imm); chk(32'(ctrl));
    push("jalr_ctrl", 32'(C_JALR)); push("jalr_imm", 32'h0);
    capture(32'h000080E7, 32'h3C);
    chk(32'(ctrl)); chk(imm);
    push("lw_ctrl", 32'(C_LOAD)); push("lw_imm", 32'hFFFFFFFC); push("lw_f3", 32'd2);
    capture(32'hFFC12083, 32'h40);
    chk(32'(ctrl)); chk(imm); chk(32'(funct3));
    push("auipc_ctrl", 32'(C_AUIPC)); push("auipc_imm", 32'h00001000);
    capture(32'h00001017, 32'h44);
    chk(32'(ctrl)); chk(imm);

    // x0 protection
    capture(32'h00700013, 32'h48);
    wb_data = 32'd7;
    en_wb   = 1'b1;
    #2;
    push("x0_nobypass", 32'h0); chk(rs1_d);
    @(posedge clk);
    #1;
    en_wb = 1'b0;
    #1;
    push("x0_after", 32'h0);
    capture(rtype(5'd0, 5'd0, 5'd0), 32'h4C);
    chk(rs1_d);

    // Illegal opcode
    push("ill_ctrl", 32'(C_ILL)); push("ill_imm", 32'h0);
    push("ill_f3", 32'd7); push("ill_f7b5", 32'd1);
    capture(32'hFFFFFFFF, 32'h50);
    chk(32'(ctrl)); chk(imm); chk(32'(funct3)); chk(32'(f7b5));

    // Mid-op reset overrides capture and write-back
    push("pre_rst_x1", 32'd5);
    capture(32'h00500093, 32'h54);
    capture(rtype(5'd1, 5'd1, 5'd0), 32'h58);
    chk(rs1_d);
    rst = 1'b1; en_id = 1'b1; instr = 32'h0020A423; pc = 32'h5C;
    en_wb = 1'b1; wb_data = 32'h999;
    @(posedge clk);
    #1;
    rst = 1'b0; en_id = 1'b0; en_wb = 1'b0;
    #1;
    push("mid_rst_pc", 32'h0); push("mid_rst_rd", 32'h0);
    push("mid_rst_ctrl", 32'(C_IALU)); push("mid_rst_imm", 32'h0);
    chk(o_pc); chk(32'(rd)); chk(32'(ctrl)); chk(imm);
    push("mid_rst_x1", 32'h0); push("mid_rst_x2", 32'h0);
    capture(rtype(5'd0, 5'd1, 5'd2), 32'h60);
    chk(rs1_d); chk(rs2_d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
